// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding read on a valid/ready IM channel,
// holds the returned word for IF/ID and squashes wrong-path fetches on redirect.
module if_fetch_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              pc_write,
  output logic              ar_valid,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              ar_ready,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data,
  output logic              r_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_stall,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;
  logic [31:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      kill_q  <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: state_d = ADDR;
      ADDR: begin
        // Address is never retracted; a redirect just marks the in-flight data as dead.
        if (redirect) begin
          kill_d = 1'b1;
          tgt_d  = redirect_pc;
        end
        if (ar_ready) state_d = DATA;
      end
      DATA: begin
        if (r_valid) begin
          if (!kill_q && !redirect) begin
            inst_d  = r_data;
            ipc_d   = pc_q;
            state_d = HOLD;
          end else begin
            kill_d  = 1'b0;
            pc_d    = redirect ? redirect_pc : tgt_q;
            state_d = ADDR;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          tgt_d  = redirect_pc;
        end
      end
      HOLD: begin
        // Redirect outranks consumption: the held word is wrong-path.
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = ADDR;
        end else if (pc_write) begin
          pc_d    = pc_q + ADDR_W'(4);
          cnt_d   = cnt_q + 32'd1;
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ar_valid    = (state_q == ADDR);
  assign ar_addr     = pc_q;
  assign r_ready     = (state_q == DATA);
  assign inst_valid  = (state_q == HOLD);
  assign fetch_stall = ~inst_valid;
  assign inst_out    = inst_q;
  assign inst_pc     = ipc_q;
  assign fetch_cnt   = cnt_q;

endmodule
